// File: rtl/fifo_arb_pkg.sv
// Shared defaults and types for the FIFO write-port arbiter.
// Types here are sized for the default configuration.
package fifo_arb_pkg;

   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);

   localparam logic [7:0] RETRY_MAX = 8'hFF;

   typedef struct packed {
      logic                valid;
      logic [DEF_ID_W-1:0] id;
   } arb_stage_t;

   // Decoded FIFO write response; anything but an ack forces a retry.
   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_ACK  = 2'd1,
      RESP_OVF  = 2'd2
   } resp_t;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin pick.
// Returns the first eligible index strictly after last_grant, wrapping around.
module fifo_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [ID_W-1:0]    last_grant,
   output logic               found,
   output logic [ID_W-1:0]    index
);

   logic [ID_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((32'(last_grant) + k) % 32'(NUM_REQ));
         if (!found && eligible[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// It tracks each write through the FIFO's registered response and retries rejected writes.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [FIFO_WIDTH-1:0]         fifo_data_in,
   output logic                          fifo_wr_en,
   input  logic                          fifo_full,
   input  logic                          fifo_almostfull,
   input  logic                          fifo_wr_ack,
   input  logic                          fifo_overflow,
   output logic [7:0]                    retry_cnt,
   output logic                          busy
);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } stage_t;

   stage_t             s1, s2, s3;
   logic [ID_W-1:0]    last_grant;
   logic [NUM_REQ-1:0] in_flight;
   logic [NUM_REQ-1:0] eligible;
   logic               blocked;
   logic               found;
   logic               grant;
   logic [ID_W-1:0]    win_id;
   resp_t              resp;

   // Masking S3 as well stops a second grant on the stale req seen alongside req_ack.
   always_comb begin
      in_flight = '0;
      if (s1.valid) in_flight[s1.id] = 1'b1;
      if (s2.valid) in_flight[s2.id] = 1'b1;
      if (s3.valid) in_flight[s3.id] = 1'b1;
   end

   assign eligible = req & ~in_flight;
   assign blocked  = fifo_full | (fifo_almostfull & s1.valid);
   assign grant    = found & ~blocked;

   fifo_rr_pick #(
      .NUM_REQ(NUM_REQ),
      .ID_W   (ID_W)
   ) u_pick (
      .eligible  (eligible),
      .last_grant(last_grant),
      .found     (found),
      .index     (win_id)
   );

   always_comb begin
      resp = RESP_NONE;
      if (fifo_wr_ack)
         resp = RESP_ACK;
      else if (fifo_overflow)
         resp = RESP_OVF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1           <= '0;
         s2           <= '0;
         s3           <= '0;
         fifo_data_in <= '0;
         last_grant   <= ID_W'(NUM_REQ - 1);
         retry_cnt    <= '0;
      end else begin
         s1.valid <= grant;
         s1.id    <= win_id;
         s2       <= s1;
         s3.valid <= s2.valid && (resp == RESP_ACK);
         s3.id    <= s2.id;
         if (grant) begin
            fifo_data_in <= req_data[32'(win_id)*FIFO_WIDTH +: FIFO_WIDTH];
            last_grant   <= win_id;
         end
         if (s2.valid && (resp != RESP_ACK) && (retry_cnt != RETRY_MAX))
            retry_cnt <= retry_cnt + 8'd1;
      end
   end

   always_comb begin
      req_ack = '0;
      if (s3.valid) req_ack[s3.id] = 1'b1;
   end

   assign fifo_wr_en = s1.valid;
   assign busy       = s1.valid | s2.valid;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter.
// A depth-8 FIFO write-side model supplies the status and the registered response.
module tb_fifo_wr_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ack;
   logic [W-1:0]   fifo_data_in;
   logic           fifo_wr_en;
   logic           fifo_full;
   logic           fifo_almostfull;
   logic           fifo_wr_ack;
   logic           fifo_overflow;
   logic [7:0]     retry_cnt;
   logic           busy;

   // FIFO model controls
   logic [3:0]     fcount;
   logic           load;
   logic [3:0]     load_val;
   logic           ovf_en;
   logic           ovf_all;
   logic [W-1:0]   ovf_target;

   int checks = 0;
   int errors = 0;
   int wr_cnt, ack_cnt, ovf_cnt;
   logic hold;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .FIFO_WIDTH(W),
      .NUM_REQ   (N)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .req_data       (req_data),
      .req_ack        (req_ack),
      .fifo_data_in   (fifo_data_in),
      .fifo_wr_en     (fifo_wr_en),
      .fifo_full      (fifo_full),
      .fifo_almostfull(fifo_almostfull),
      .fifo_wr_ack    (fifo_wr_ack),
      .fifo_overflow  (fifo_overflow),
      .retry_cnt      (retry_cnt),
      .busy           (busy)
   );

   assign fifo_full       = (fcount == 4'd8);
   assign fifo_almostfull = (fcount == 4'd7);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fcount        <= 4'd0;
         fifo_wr_ack   <= 1'b0;
         fifo_overflow <= 1'b0;
      end else begin
         fifo_wr_ack   <= 1'b0;
         fifo_overflow <= 1'b0;
         if (load)
            fcount <= load_val;
         else if (fifo_wr_en) begin
            if (ovf_all || (ovf_en && fifo_data_in == ovf_target) || fcount == 4'd8)
               fifo_overflow <= 1'b1;
            else begin
               fifo_wr_ack <= 1'b1;
               fcount      <= fcount + 4'd1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      wr_cnt  += int'(fifo_wr_en);
      ovf_cnt += int'(fifo_overflow);
      ack_cnt += $countones(req_ack);
   endtask

   task automatic clear_counts();
      wr_cnt  = 0;
      ack_cnt = 0;
      ovf_cnt = 0;
   endtask

   initial begin
      rst        = 1'b1;
      req        = '0;
      load       = 1'b0;
      load_val   = 4'd0;
      ovf_en     = 1'b0;
      ovf_all    = 1'b0;
      ovf_target = '0;
      hold       = 1'b0;
      clear_counts();
      for (int i = 0; i < N; i++)
         req_data[i*W +: W] = 16'(16'hA000 + i);

      // reset asserted mid-stream
      repeat (2) step();
      rst = 1'b0;
      req = 4'b1111;
      repeat (3) step();
      rst = 1'b1;
      #1;
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_data", 32'(fifo_data_in), 32'd0);
      check("rst_ack", 32'(req_ack), 32'd0);
      check("rst_retry", 32'(retry_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      step();
      rst = 1'b0;

      // round-robin with all four requesters on an empty FIFO
      for (int k = 0; k < 5; k++) begin
         step();
         check("rr_wr_en", 32'(fifo_wr_en), 32'd1);
         check("rr_data", 32'(fifo_data_in), 32'(16'hA000 + (k % 4)));
         check("rr_busy", 32'(busy), 32'd1);
         if (k >= 2)
            check("rr_ack", 32'(req_ack), 32'(1 << ((k - 2) % 4)));
         else
            check("rr_ack", 32'(req_ack), 32'd0);
      end
      req = '0;
      step();
      check("rr_ack_id3", 32'(req_ack), 32'h8);
      check("rr_idle_wr_en", 32'(fifo_wr_en), 32'd0);
      step();
      check("rr_ack_id0", 32'(req_ack), 32'h1);
      check("rr_idle_busy", 32'(busy), 32'd0);

      // almostfull throttle: 7 of 8 slots used
      load     = 1'b1;
      load_val = 4'd7;
      step();
      load = 1'b0;
      clear_counts();
      req = 4'b0011;
      repeat (8) step();
      req = '0;
      repeat (3) step();
      check("af_writes", 32'(wr_cnt), 32'd1);
      check("af_acks", 32'(ack_cnt), 32'd1);
      check("af_ovf", 32'(ovf_cnt), 32'd0);
      check("af_retry", 32'(retry_cnt), 32'd0);
      check("af_full", 32'(fifo_full), 32'd1);
      load     = 1'b1;
      load_val = 4'd0;
      step();
      load = 1'b0;

      // overflow on requester 2's first write, then retry
      clear_counts();
      ovf_target = 16'hA002;
      ovf_en     = 1'b1;
      req        = 4'b0100;
      for (int c = 0; c < 14; c++) begin
         step();
         if (fifo_overflow) ovf_en = 1'b0;
         if (req_ack[2]) begin
            check("ovf_ack_after_reject", 32'(ovf_cnt), 32'd1);
            req = '0;
         end
      end
      check("ovf_count", 32'(ovf_cnt), 32'd1);
      check("ovf_acks", 32'(ack_cnt), 32'd1);
      check("ovf_writes", 32'(wr_cnt), 32'd2);
      check("ovf_retry", 32'(retry_cnt), 32'd1);

      // producer holds req one cycle past its ack
      clear_counts();
      req = 4'b0010;
      for (int c = 0; c < 14; c++) begin
         step();
         if (hold) begin
            req  = '0;
            hold = 1'b0;
         end
         if (req_ack[1]) hold = 1'b1;
      end
      check("dbl_writes", 32'(wr_cnt), 32'd1);
      check("dbl_acks", 32'(ack_cnt), 32'd1);
      check("dbl_busy", 32'(busy), 32'd0);

      // retry counter saturation
      clear_counts();
      ovf_all = 1'b1;
      req     = 4'b1111;
      for (int c = 0; c < 3000 && ovf_cnt < 300; c++)
         step();
      check("sat_reached_300", 32'(ovf_cnt >= 300), 32'd1);
      check("sat_retry", 32'(retry_cnt), 32'd255);
      repeat (10) step();
      check("sat_retry_hold", 32'(retry_cnt), 32'd255);
      check("sat_no_ack", 32'(ack_cnt), 32'd0);
      req     = '0;
      ovf_all = 1'b0;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
